// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction-memory handshake and next-PC selection.
// Presents one instruction at a time and redirects on acceptance with zero penalty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Imem_addr_out,
    output logic        Imem_req_out,
    input  logic        Imem_ack_in,
    input  logic [31:0] Imem_data_in,
    output logic [31:0] Instr_out,
    output logic [31:0] Pc_out,
    output logic [31:0] Pc_plus4_out,
    output logic        Instr_valid_out,
    input  logic        Instr_ready_in,
    input  logic        Branch_in,
    input  logic        Jump_in,
    input  logic        Jump_reg_in,
    input  logic [31:0] Target_reg_in,
    output logic [31:0] Retired_count_out
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc_out_q, pc_out_d, cnt_q, cnt_d;
    logic [31:0] p4, next_pc;
    logic        accept;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            pc_out_q <= RESET_PC;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            cnt_q    <= cnt_d;
        end
    end
    // Jump beats branch; JR/JALR targets are forced word aligned.
    always_comb begin
        p4      = pc_out_q + 32'd4;
        next_pc = (Jump_in && Jump_reg_in) ? {Target_reg_in[31:2], 2'b00} :
                  Jump_in                  ? {p4[31:28], instr_q[25:0], 2'b00} :
                  Branch_in                ? p4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00} :
                                             p4;
        accept  = (state_q == ISSUE) && Instr_ready_in;
    end
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH: if (Imem_ack_in) begin
                state_d  = ISSUE;
                instr_d  = Imem_data_in;
                pc_out_d = pc_q;
            end
            ISSUE: if (accept) begin
                state_d = FETCH;
                pc_d    = next_pc;
                cnt_d   = cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    assign Imem_addr_out     = pc_q;
    assign Imem_req_out      = (state_q == FETCH);
    assign Instr_valid_out   = (state_q == ISSUE);
    assign Instr_out         = instr_q;
    assign Pc_out            = pc_out_q;
    assign Pc_plus4_out      = p4;
    assign Retired_count_out = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a behavioural model.
module tb_fetch_unit;
    logic        clk = 0, reset = 1;
    logic [31:0] Imem_addr_out, Imem_data_in = 0, Instr_out, Pc_out, Pc_plus4_out;
    logic [31:0] Target_reg_in = 0, Retired_count_out;
    logic        Imem_req_out, Imem_ack_in = 0, Instr_valid_out, Instr_ready_in = 0;
    logic        Branch_in = 0, Jump_in = 0, Jump_reg_in = 0;
    int          checks = 0, errors = 0;
    logic [31:0] m_pc, m_cur, m_instr, m_cnt;

    fetch_unit #(.RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset),
        .Imem_addr_out(Imem_addr_out), .Imem_req_out(Imem_req_out),
        .Imem_ack_in(Imem_ack_in), .Imem_data_in(Imem_data_in),
        .Instr_out(Instr_out), .Pc_out(Pc_out), .Pc_plus4_out(Pc_plus4_out),
        .Instr_valid_out(Instr_valid_out), .Instr_ready_in(Instr_ready_in),
        .Branch_in(Branch_in), .Jump_in(Jump_in), .Jump_reg_in(Jump_reg_in),
        .Target_reg_in(Target_reg_in), .Retired_count_out(Retired_count_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_next(input logic [31:0] pc, ins, input logic br, j, jr,
                                             input logic [31:0] t);
        logic [31:0] p4;
        int          off;
        p4  = pc + 32'd4;
        off = $signed(ins[15:0]);
        if (j && jr) return t & ~32'd3;
        if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (br) return p4 + 32'(off * 4);
        return p4;
    endfunction

    task automatic scramble();
        Branch_in = 1'($urandom); Jump_in = 1'($urandom); Jump_reg_in = 1'($urandom);
        Target_reg_in = $urandom;
    endtask

    // Called on a falling edge while fetching; returns on the falling edge after capture.
    task automatic fetch(input int w, input logic [31:0] d);
        for (int i = 0; i < w; i++) begin
            scramble();
            @(negedge clk);
        end
        Imem_ack_in = 1; Imem_data_in = d;
        m_cur = m_pc; m_instr = d;
        @(negedge clk);
        Imem_ack_in = 0; Imem_data_in = $urandom;
    endtask

    task automatic accept(input logic br, j, jr, input logic [31:0] t);
        Instr_ready_in = 1; Branch_in = br; Jump_in = j; Jump_reg_in = jr; Target_reg_in = t;
        m_pc = ref_next(m_cur, m_instr, br, j, jr, t);
        m_cnt = m_cnt + 1;
        @(negedge clk);
        Instr_ready_in = 0;
        scramble();
    endtask

    task automatic go_to(input logic [31:0] a);
        fetch(0, $urandom);
        accept(0, 1, 1, a);
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        checks++; if (Imem_addr_out !== 32'h100) begin errors++; $display("FAIL rst_addr got %h exp %h", Imem_addr_out, 32'h100); end
        checks++; if (Imem_req_out !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", Imem_req_out); end
        checks++; if (Instr_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", Instr_valid_out); end
        checks++; if (Instr_out !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", Instr_out); end
        checks++; if (Pc_out !== 32'h100 || Pc_plus4_out !== 32'h104) begin errors++; $display("FAIL rst_pc got %h/%h exp 100/104", Pc_out, Pc_plus4_out); end
        checks++; if (Retired_count_out !== 32'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", Retired_count_out); end
        reset = 0; m_pc = 32'h100; m_cnt = 0;
        @(negedge clk);
        checks++; if (Imem_req_out !== 1'b1 || Instr_valid_out !== 1'b0) begin errors++; $display("FAIL cyc1 req/valid got %b%b exp 10", Imem_req_out, Instr_valid_out); end
        checks++; if (Imem_addr_out !== 32'h100) begin errors++; $display("FAIL cyc1_addr got %h exp 100", Imem_addr_out); end
        fetch(0, 32'h2108_0001);
        checks++; if (Instr_valid_out !== 1'b1 || Imem_req_out !== 1'b0) begin errors++; $display("FAIL cyc3 valid/req got %b%b exp 10", Instr_valid_out, Imem_req_out); end
        checks++; if (Instr_out !== 32'h2108_0001) begin errors++; $display("FAIL first_instr got %h exp 21080001", Instr_out); end
        checks++; if (Pc_out !== 32'h100 || Pc_plus4_out !== 32'h104) begin errors++; $display("FAIL first_pc got %h/%h exp 100/104", Pc_out, Pc_plus4_out); end
        accept(0, 0, 0, $urandom);
        checks++; if (Imem_addr_out !== 32'h104 || Retired_count_out !== 32'd1) begin errors++; $display("FAIL first_accept got %h cnt %0d exp 104 cnt 1", Imem_addr_out, Retired_count_out); end
    endtask

    task automatic test_branch();
        go_to(32'h200);
        fetch(0, 32'h1234_FFFE);
        accept(1, 0, 0, $urandom);
        checks++; if (Imem_addr_out !== 32'h1FC) begin errors++; $display("FAIL br_back got %h exp 1fc", Imem_addr_out); end
        go_to(32'h200);
        fetch(1, 32'h1000_0003);
        accept(1, 0, 0, $urandom);
        checks++; if (Imem_addr_out !== 32'h210) begin errors++; $display("FAIL br_fwd got %h exp 210", Imem_addr_out); end
    endtask

    task automatic test_jump();
        go_to(32'hA000_0000);
        fetch(0, 32'h0800_0040);
        accept(0, 1, 0, $urandom);
        checks++; if (Imem_addr_out !== 32'hA000_0100) begin errors++; $display("FAIL j got %h exp a0000100", Imem_addr_out); end
        fetch(0, $urandom);
        accept(0, 1, 1, 32'h0000_1237);
        checks++; if (Imem_addr_out !== 32'h1234) begin errors++; $display("FAIL jr got %h exp 1234", Imem_addr_out); end
        fetch(0, 32'h0800_0100);
        accept(1, 1, 0, $urandom);
        checks++; if (Imem_addr_out !== 32'h400) begin errors++; $display("FAIL j_over_br got %h exp 400", Imem_addr_out); end
    endtask

    task automatic test_stall();
        logic [31:0] a0, d;
        a0 = m_pc;
        for (int i = 0; i < 4; i++) begin
            checks++; if (Imem_req_out !== 1'b1 || Imem_addr_out !== a0) begin errors++; $display("FAIL fetch_hold[%0d] req %b addr %h exp 1 %h", i, Imem_req_out, Imem_addr_out, a0); end
            if (i < 3) begin scramble(); @(negedge clk); end
        end
        d = $urandom;
        fetch(0, d);
        for (int i = 0; i < 5; i++) begin
            Branch_in = ~Branch_in; Imem_ack_in = (i == 2); Imem_data_in = ~d;
            @(negedge clk);
            checks++; if (Instr_valid_out !== 1'b1 || Instr_out !== d || Pc_out !== a0) begin errors++; $display("FAIL issue_hold[%0d] v %b instr %h pc %h exp 1 %h %h", i, Instr_valid_out, Instr_out, Pc_out, d, a0); end
            checks++; if (Imem_addr_out !== a0 || Retired_count_out !== m_cnt) begin errors++; $display("FAIL issue_pc[%0d] got %h cnt %0d exp %h cnt %0d", i, Imem_addr_out, Retired_count_out, a0, m_cnt); end
        end
        Imem_ack_in = 0;
        accept(0, 0, 0, $urandom);
        checks++; if (Imem_addr_out !== a0 + 32'd4) begin errors++; $display("FAIL stall_accept got %h exp %h", Imem_addr_out, a0 + 32'd4); end
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFF);
        fetch(0, 32'h0000_0000);
        checks++; if (Pc_out !== 32'hFFFF_FFFC || Pc_plus4_out !== 32'h0) begin errors++; $display("FAIL wrap_p4 got %h/%h exp fffffffc/0", Pc_out, Pc_plus4_out); end
        accept(0, 0, 0, $urandom);
        checks++; if (Imem_addr_out !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", Imem_addr_out); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            logic br, j, jr;
            fetch($urandom_range(0, 3), $urandom);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin scramble(); @(negedge clk); end
            checks++; if (Instr_valid_out !== 1'b1 || Instr_out !== m_instr || Pc_out !== m_cur || Pc_plus4_out !== m_cur + 32'd4) begin errors++; $display("FAIL rnd_issue[%0d] v %b i %h pc %h p4 %h exp 1 %h %h", n, Instr_valid_out, Instr_out, Pc_out, Pc_plus4_out, m_instr, m_cur); end
            br = ($urandom_range(0, 2) == 0); j = ($urandom_range(0, 3) == 0); jr = 1'($urandom);
            accept(br, j, jr, $urandom);
            checks++; if (Imem_addr_out !== m_pc || Retired_count_out !== m_cnt || Imem_req_out !== 1'b1) begin errors++; $display("FAIL rnd_next[%0d] got %h cnt %0d req %b exp %h cnt %0d", n, Imem_addr_out, Retired_count_out, Imem_req_out, m_pc, m_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        #1 reset = 1;
        #1;
        checks++; if (Imem_req_out !== 1'b0 || Imem_addr_out !== 32'h100) begin errors++; $display("FAIL rst_fetch req %b addr %h exp 0 100", Imem_req_out, Imem_addr_out); end
        @(negedge clk);
        reset = 0; Imem_ack_in = 1; Imem_data_in = 32'hDEAD_BEEF;
        m_pc = 32'h100; m_cnt = 0;
        @(negedge clk);
        Imem_ack_in = 0;
        checks++; if (Instr_valid_out !== 1'b0 || Instr_out !== 32'h0 || Imem_req_out !== 1'b1) begin errors++; $display("FAIL late_ack v %b instr %h req %b exp 0 0 1", Instr_valid_out, Instr_out, Imem_req_out); end
        fetch(0, 32'h0000_0042);
        checks++; if (Instr_out !== 32'h42 || Pc_out !== 32'h100) begin errors++; $display("FAIL refetch got %h pc %h exp 42 100", Instr_out, Pc_out); end
        Instr_ready_in = 1;
        #1 reset = 1;
        #1;
        checks++; if (Instr_valid_out !== 1'b0 || Retired_count_out !== 32'h0 || Instr_out !== 32'h0) begin errors++; $display("FAIL rst_issue v %b cnt %0d instr %h exp 0 0 0", Instr_valid_out, Retired_count_out, Instr_out); end
        @(negedge clk);
        Instr_ready_in = 0; reset = 0;
        @(negedge clk);
        checks++; if (Imem_req_out !== 1'b1 || Imem_addr_out !== 32'h100 || Retired_count_out !== 32'h0) begin errors++; $display("FAIL post_rst req %b addr %h cnt %0d exp 1 100 0", Imem_req_out, Imem_addr_out, Retired_count_out); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
